// File: rtl/payload_receiver.sv
// Frame receiver for an 8b/10b symbol stream: locks on K28.1 commas, collects a
// fixed-length payload, checks its CRC-16/BUYPASS and publishes good frames.
module payload_receiver #(
   parameter int PAYLOAD_BYTES = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       byte_tick,
   input  logic [7:0]                 din,
   input  logic                       is_comma,
   input  logic                       code_err,
   output logic [PAYLOAD_BYTES*8-1:0] payload,
   output logic                       valid,
   input  logic                       ready,
   output logic                       locked,
   output logic [CNT_WIDTH-1:0]       crc_err_cnt,
   output logic [CNT_WIDTH-1:0]       frame_err_cnt,
   output logic [CNT_WIDTH-1:0]       overrun_cnt
);

   localparam int PW    = PAYLOAD_BYTES * 8;
   localparam int IDX_W = $clog2(PAYLOAD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

   typedef enum logic [2:0] {
      HUNT, WAIT_DATA, RX_PAYLOAD, RX_CRC_H, RX_CRC_L, EXPECT_COMMA
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      crc;
   logic [15:0]      rx_crc;
   logic [IDX_W-1:0] idx;
   logic [PW-1:0]    shadow;
   logic             crc_ok;

   logic take_first, take_byte, take_crc_h, take_crc_l;
   logic publish, crc_err_ev, frame_err_ev;

   // MSB-first CRC-16 step, polynomial 0x8005
   function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
      return r;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   assign crc_ok = (rx_crc == crc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HUNT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (byte_tick) begin
         if (code_err) begin
            state_nxt = HUNT;
         end else begin
            case (state)
               HUNT:         if (is_comma) state_nxt = WAIT_DATA;
               WAIT_DATA:    if (!is_comma) state_nxt = RX_PAYLOAD;
               RX_PAYLOAD:   if (is_comma) state_nxt = WAIT_DATA;
                             else if (idx == LAST_IDX) state_nxt = RX_CRC_H;
               RX_CRC_H:     state_nxt = is_comma ? WAIT_DATA : RX_CRC_L;
               RX_CRC_L:     state_nxt = is_comma ? WAIT_DATA : EXPECT_COMMA;
               EXPECT_COMMA: state_nxt = is_comma ? WAIT_DATA : HUNT;
               default:      state_nxt = HUNT;
            endcase
         end
      end
   end

   // code_err outside HUNT aborts the frame before the comma is looked at
   always_comb begin
      locked       = (state != HUNT);
      take_first   = 1'b0;
      take_byte    = 1'b0;
      take_crc_h   = 1'b0;
      take_crc_l   = 1'b0;
      publish      = 1'b0;
      crc_err_ev   = 1'b0;
      frame_err_ev = 1'b0;
      if (byte_tick && state != HUNT) begin
         if (code_err) begin
            frame_err_ev = 1'b1;
         end else begin
            case (state)
               WAIT_DATA:    take_first = !is_comma;
               RX_PAYLOAD:   begin frame_err_ev = is_comma; take_byte  = !is_comma; end
               RX_CRC_H:     begin frame_err_ev = is_comma; take_crc_h = !is_comma; end
               RX_CRC_L:     begin frame_err_ev = is_comma; take_crc_l = !is_comma; end
               EXPECT_COMMA: begin
                  publish      = is_comma && crc_ok;
                  crc_err_ev   = is_comma && !crc_ok;
                  frame_err_ev = !is_comma;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc <= 16'h0000;
         idx <= '0;
      end else if (take_first) begin
         crc <= crc16_upd(16'h0000, din);
         idx <= IDX_W'(1);
      end else if (take_byte) begin
         crc <= crc16_upd(crc, din);
         idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
   end

   // Shift-in keeps the first byte in the MSBs once the whole payload has arrived
   always_ff @(posedge clk) begin
      if (take_first || take_byte) shadow <= {shadow[PW-9:0], din};
      if (take_crc_h)              rx_crc[15:8] <= din;
      if (take_crc_l)              rx_crc[7:0]  <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         payload       <= '0;
         valid         <= 1'b0;
         overrun_cnt   <= '0;
         crc_err_cnt   <= '0;
         frame_err_cnt <= '0;
      end else begin
         if (publish) begin
            payload <= shadow;
            valid   <= 1'b1;
            if (valid && !ready) overrun_cnt <= sat_inc(overrun_cnt);
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (crc_err_ev)   crc_err_cnt   <= sat_inc(crc_err_cnt);
         if (frame_err_ev) frame_err_cnt <= sat_inc(frame_err_cnt);
      end
   end

endmodule

// File: tb/tb_payload_receiver.sv
// Directed bench for payload_receiver with 9-byte frames and 2-bit counters
// so that counter saturation is reachable in a short run.
module tb_payload_receiver;

   localparam int PB = 9;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          byte_tick;
   logic [7:0]    din;
   logic          is_comma;
   logic          code_err;
   logic [PB*8-1:0] payload;
   logic          valid;
   logic          ready;
   logic          locked;
   logic [CW-1:0] crc_err_cnt, frame_err_cnt, overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [71:0] P1 = 72'h313233343536373839;  // "123456789"
   localparam logic [71:0] P2 = 72'h414243444546474849;  // "ABCDEFGHI"

   payload_receiver #(.PAYLOAD_BYTES(PB), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n), .byte_tick(byte_tick), .din(din),
      .is_comma(is_comma), .code_err(code_err), .payload(payload),
      .valid(valid), .ready(ready), .locked(locked),
      .crc_err_cnt(crc_err_cnt), .frame_err_cnt(frame_err_cnt),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bit-serial CRC-16/BUYPASS reference over a 9-byte payload
   function automatic logic [15:0] ref_crc(input logic [71:0] pl);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 71; i >= 0; i--) begin
         fb = c[15] ^ pl[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h8005;
      end
      return c;
   endfunction

   // Called at posedge+1; returns at the following posedge+1 with the symbol consumed
   task automatic send_sym(input logic [7:0] d, input logic k, input logic e);
      byte_tick = 1'b1; din = d; is_comma = k; code_err = e;
      @(posedge clk); #1;
      byte_tick = 1'b0; din = 8'hA5; is_comma = 1'b1; code_err = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_bytes(input logic [71:0] pl, input int n);
      for (int i = 0; i < n; i++) send_sym(pl[71-8*i -: 8], 1'b0, 1'b0);
   endtask

   // Payload, CRC and trailing comma; optional idle gap after every symbol
   task automatic send_frame(input logic [71:0] pl, input logic [15:0] c, input logic gaps);
      for (int i = 0; i < PB; i++) begin
         send_sym(pl[71-8*i -: 8], 1'b0, 1'b0);
         if (gaps) idle(1);
      end
      send_sym(c[15:8], 1'b0, 1'b0);
      if (gaps) idle(2);
      send_sym(c[7:0], 1'b0, 1'b0);
      if (gaps) idle(1);
      send_sym(8'hBC, 1'b1, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; byte_tick = 1'b0; din = 8'h00;
      is_comma = 1'b0; code_err = 1'b0; ready = 1'b1;
      idle(3);
      check("rst_locked", locked, 0);
      check("rst_valid", valid, 0);
      check("rst_payload", payload, 0);
      check("rst_cnts", {crc_err_cnt, frame_err_cnt, overrun_cnt}, 0);
      reset_n = 1'b1;
      idle(1);

      // Known-answer frame, CRC 0xFEE8
      send_sym(8'hBC, 1'b1, 1'b0);
      check("lock_on_comma", locked, 1);
      send_frame(P1, 16'hFEE8, 1'b0);
      check("good_valid", valid, 1);
      check("good_payload", payload, P1);
      check("good_cnts", {crc_err_cnt, frame_err_cnt, overrun_cnt}, 0);
      idle(1);
      check("good_valid_1cyc", valid, 0);

      // Bad CRC low byte, then recovery
      send_frame(P1, 16'hFEE9, 1'b0);
      check("badcrc_valid", valid, 0);
      check("badcrc_cnt", crc_err_cnt, 1);
      check("badcrc_locked", locked, 1);
      send_frame(P1, 16'hFEE8, 1'b0);
      check("after_badcrc_valid", valid, 1);
      idle(1);

      // Comma after payload byte 4 resyncs; next frame has idle gaps with junk on the bus
      send_bytes(P1, 5);
      send_sym(8'hBC, 1'b1, 1'b0);
      check("early_comma_ferr", frame_err_cnt, 1);
      check("early_comma_valid", valid, 0);
      check("early_comma_locked", locked, 1);
      send_frame(P2, ref_crc(P2), 1'b1);
      check("resync_valid", valid, 1);
      check("resync_payload", payload, P2);
      idle(1);

      // code_err on byte 2 drops lock until the next comma
      send_bytes(P1, 2);
      send_sym(8'h33, 1'b0, 1'b1);
      check("codeerr_ferr", frame_err_cnt, 2);
      check("codeerr_locked", locked, 0);
      send_bytes(P1, 9);
      send_sym(8'hFE, 1'b0, 1'b0);
      send_sym(8'hE8, 1'b0, 1'b0);
      check("hunt_ignores_data", locked, 0);
      check("hunt_ferr_hold", frame_err_cnt, 2);
      send_sym(8'hBC, 1'b1, 1'b0);
      check("hunt_comma_valid", valid, 0);
      check("hunt_comma_locked", locked, 1);
      send_frame(P1, 16'hFEE8, 1'b0);
      check("after_hunt_payload", payload, P1);
      idle(1);

      // Overrun with ready low
      ready = 1'b0;
      send_frame(P1, 16'hFEE8, 1'b0);
      send_frame(P2, ref_crc(P2), 1'b0);
      check("ovr_valid", valid, 1);
      check("ovr_payload", payload, P2);
      check("ovr_cnt", overrun_cnt, 1);
      idle(2);
      check("ovr_valid_hold", valid, 1);
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      check("ovr_consumed", valid, 0);
      ready = 1'b1;

      // Asynchronous reset mid-payload
      send_bytes(P2, 4);
      reset_n = 1'b0;
      #1;
      check("async_rst_locked", locked, 0);
      check("async_rst_payload", payload, 0);
      check("async_rst_cnts", {crc_err_cnt, frame_err_cnt, overrun_cnt}, 0);
      idle(1);
      reset_n = 1'b1;
      send_bytes(P1, 9);
      send_sym(8'hFE, 1'b0, 1'b0);
      send_sym(8'hE8, 1'b0, 1'b0);
      check("postrst_locked", locked, 0);
      send_sym(8'hBC, 1'b1, 1'b0);
      check("postrst_no_pub", valid, 0);
      check("postrst_locked_comma", locked, 1);
      send_frame(P2, ref_crc(P2), 1'b0);
      check("postrst_payload", payload, P2);
      idle(1);

      // Counter saturation at 3
      for (int i = 0; i < 4; i++) send_frame(P1, 16'h0000, 1'b0);
      check("crc_err_sat", crc_err_cnt, 3);
      for (int i = 0; i < 4; i++) begin
         send_sym(8'h11, 1'b0, 1'b0);
         send_sym(8'hBC, 1'b1, 1'b0);
      end
      check("frame_err_sat", frame_err_cnt, 3);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(P1, 16'hFEE8, 1'b0);
      check("overrun_sat", overrun_cnt, 3);
      ready = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/payload_receiver.md
PAYLOAD_RECEIVER -- requirements
Module: payload_receiver

Interface
REQ-001 The module SHALL have parameter PAYLOAD_BYTES, default 8, giving the number of payload bytes per frame (2..32).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, giving the width of each error/overrun counter.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 byte_tick  in  1  high one cycle when din/is_comma/code_err carry a newly decoded symbol.
REQ-006 din  in  8  decoded data byte from the 8b/10b decoder.
REQ-007 is_comma  in  1  symbol is K28.1.
REQ-008 code_err  in  1  symbol had a disparity or code violation.
REQ-009 payload  out  PAYLOAD_BYTES*8  last good frame; first received byte in the MSBs.
REQ-010 valid  out  1  payload holds an unconsumed good frame.
REQ-011 ready  in  1  consumer accepts payload when valid&&ready.
REQ-012 locked  out  1  high when state is not HUNT.
REQ-013 crc_err_cnt, frame_err_cnt, overrun_cnt  out  CNT_WIDTH each  saturating event counters.

Function
REQ-014 The wire frame SHALL be: PAYLOAD_BYTES data bytes, CRC high byte, CRC low byte, then one K28.1 comma; idle commas are allowed between frames.
REQ-015 The CRC SHALL be CRC-16/BUYPASS: poly 0x8005, init 0x0000, no reflection, no output XOR, MSB-first over the payload bytes only.
REQ-016 Inputs SHALL be sampled only in cycles with byte_tick=1; all state, the CRC and counters hold otherwise.
REQ-017 The FSM SHALL have states HUNT, WAIT_DATA, RX_PAYLOAD, RX_CRC_H, RX_CRC_L, EXPECT_COMMA.
REQ-018 HUNT: a comma -> WAIT_DATA; data is ignored and no counter changes.
REQ-019 WAIT_DATA: a comma stays; data stores byte 0, seeds the CRC with it, and goes to RX_PAYLOAD with byte index 1.
REQ-020 RX_PAYLOAD: data stores byte[index] into the shadow register and updates the CRC; after byte PAYLOAD_BYTES-1 -> RX_CRC_H.
REQ-021 RX_CRC_H: data latches the CRC high byte -> RX_CRC_L; RX_CRC_L: data latches the CRC low byte -> EXPECT_COMMA.
REQ-022 EXPECT_COMMA on a comma: if received CRC == computed CRC, publish; otherwise increment crc_err_cnt; then -> WAIT_DATA.
REQ-023 EXPECT_COMMA on data: increment frame_err_cnt, discard the frame, -> HUNT.
REQ-024 A comma in RX_PAYLOAD, RX_CRC_H or RX_CRC_L SHALL increment frame_err_cnt, discard the frame, and go to WAIT_DATA (resync).
REQ-025 code_err in any state other than HUNT SHALL increment frame_err_cnt, discard the frame, and go to HUNT; in HUNT it is ignored.
REQ-026 code_err SHALL take priority over is_comma in the same symbol.
REQ-027 Publish SHALL copy the shadow register to payload and set valid, both visible on the cycle after the trailing-comma tick.
REQ-028 payload SHALL change only on publish; shadow bytes of discarded frames never reach payload.
REQ-029 valid SHALL clear on the cycle after valid&&ready, unless a publish occurs in the same cycle, in which case valid stays 1 with the new data.
REQ-030 A publish while valid=1 and ready=0 SHALL overwrite payload and increment overrun_cnt.
REQ-031 All counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-032 When two counter events coincide in one cycle, each affected counter SHALL increment by 1.

Reset
REQ-033 When reset_n=0, the block SHALL immediately (asynchronously) force: state=HUNT, locked=0, valid=0, payload=0, all counters=0, CRC=0, byte index=0.
REQ-034 Reset during a frame SHALL discard the frame; after release, the block SHALL publish nothing until a comma followed by a complete, good frame.
REQ-035 Deassertion SHALL be synchronized to clk by the integrating design; the block SHALL operate from the first clock edge after release.

Verification
REQ-036 PAYLOAD_BYTES=9, ready=1: comma, ASCII "123456789", 0xFE, 0xE8, comma -> valid for 1 cycle with payload=0x313233343536373839; all counters 0.
REQ-037 Same frame with CRC low byte 0xE9 -> valid stays 0; crc_err_cnt=1; locked=1; the next good frame still publishes.
REQ-038 Comma injected after payload byte 4 -> frame_err_cnt=1, no publish, state WAIT_DATA; an immediately following full good frame publishes.
REQ-039 code_err on payload byte 2 -> frame_err_cnt=1, locked=0; data bytes before the next comma are ignored; resumes after a comma.
REQ-040 ready=0, two good frames -> valid=1 holding the second frame; overrun_cnt=1; then ready=1 for one cycle -> valid=0.
REQ-041 reset_n pulsed low mid-payload, then frames sent without a leading comma -> no publish and locked=0 until the first comma.
